// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine.
// A captured 128-bit state is transformed in place, COLS_PER_CYCLE columns
// per BUSY cycle, and then held in DONE until the downstream handshake.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit ENABLE_INV     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] state_i,
  input  logic         inv_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] state_o,
  output logic         busy_o
);

  // Only 1, 2 and 4 columns per cycle divide the four columns evenly.
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Step and last counter value; with 4 columns per cycle the step wraps to 0.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bytewise xtime over a whole column word.
  function automatic logic [31:0] xtime4(input logic [31:0] w);
    return {xtime(w[31:24]), xtime(w[23:16]), xtime(w[15:8]), xtime(w[7:0])};
  endfunction

  // Rotations that place byte a_(r+k) into byte lane r.
  function automatic logic [31:0] rot8(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [31:0] rot16(input logic [31:0] w);
    return {w[15:0], w[31:16]};
  endfunction

  function automatic logic [31:0] rot24(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [31:0] r1;
    r1 = rot8(c);
    return xtime4(c) ^ xtime4(r1) ^ r1 ^ rot16(c) ^ rot24(c);
  endfunction

  // b_r = e*a_r ^ b*a_(r+1) ^ d*a_(r+2) ^ 9*a_(r+3); xtime commutes with
  // the byte rotation, so multiples are built once and then rotated.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [31:0] x2, x4, x8;
    x2 = xtime4(c);
    x4 = xtime4(x2);
    x8 = xtime4(x4);
    return (x8 ^ x4 ^ x2) ^ rot8(x8 ^ x2 ^ c) ^ rot16(x8 ^ x4 ^ c) ^ rot24(x8 ^ c);
  endfunction

  logic [1:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic         inv_q, inv_d;
  logic         rdy_en_q;

  logic [1:0]  slot_idx [COLS_PER_CYCLE];
  logic [31:0] col_out  [COLS_PER_CYCLE];

  // One transform slot per column handled in a BUSY cycle.
  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_slot
    logic [31:0] col_in;
    assign slot_idx[gi] = cnt_q + 2'(gi);
    assign col_in       = data_q[32*slot_idx[gi] +: 32];
    if (ENABLE_INV) begin : g_inv
      assign col_out[gi] = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
    end else begin : g_fwd
      assign col_out[gi] = mix_fwd(col_in);
    end
  end

  assign ready_o = (state_q == ST_IDLE) && rdy_en_q;
  assign valid_o = (state_q == ST_DONE);
  assign busy_o  = (state_q != ST_IDLE);
  assign state_o = valid_o ? data_q : 128'd0;

  // Next-state: capture in IDLE, transform columns in BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && ready_o) begin
          data_d  = state_i;
          inv_d   = inv_i & ENABLE_INV;
          cnt_d   = 2'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int s = 0; s < COLS_PER_CYCLE; s++) begin
          data_d[32*slot_idx[s] +: 32] = col_out[s];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      data_q  <= 128'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

  // Keeps ready_o low until the first clock edge after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle)
// checked against a generic GF(2^8) multiply model through a scoreboard.
module tb_mix_columns_iter;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]        rst;
  logic [NDUT-1:0]        valid_in;
  logic [NDUT-1:0]        ready_out;
  logic [NDUT-1:0][127:0] state_in;
  logic [NDUT-1:0]        inv_in;
  logic [NDUT-1:0]        valid_out;
  logic [NDUT-1:0]        ready_in;
  logic [NDUT-1:0][127:0] state_out;
  logic [NDUT-1:0]        busy_out;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    mix_columns_iter #(
      .COLS_PER_CYCLE(1 << gi),
      .ENABLE_INV    (1)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst[gi]),
      .valid_i(valid_in[gi]),
      .ready_o(ready_out[gi]),
      .state_i(state_in[gi]),
      .inv_i  (inv_in[gi]),
      .valid_o(valid_out[gi]),
      .ready_i(ready_in[gi]),
      .state_o(state_out[gi]),
      .busy_o (busy_out[gi])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] sb[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  col, w, coef;
    logic [7:0]   acc;
    coef = inv ? 32'h090d0b0e : 32'h01010302;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[32*c +: 32];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          w = (j == 0) ? col : ((col >> (8*j)) | (col << (32 - 8*j)));
          acc = acc ^ gmul(w[8*r +: 8], coef[8*j +: 8]);
        end
        o[32*c + 8*r +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One transaction on instance k, with bp cycles of backpressure in DONE
  // and stray valid pulses whenever bp is non-zero.
  task automatic run_one(input int k, input logic [127:0] st, input logic inv,
                         input int bp, output logic [127:0] res);
    int lat;
    logic [127:0] exp;
    logic [127:0] hold;
    @(negedge clk);
    chk("ready_idle", 128'(ready_out[k]), 128'd1);
    valid_in[k] = 1'b1;
    state_in[k] = st;
    inv_in[k]   = inv;
    ready_in[k] = 1'b0;
    sb.push_back(model(st, inv));
    @(negedge clk);
    valid_in[k] = 1'b0;
    chk("busy_after_accept", 128'(busy_out[k]), 128'd1);
    chk("ready_in_busy", 128'(ready_out[k]), 128'd0);
    lat = 0;
    while (!valid_out[k] && lat < 16) begin
      if (bp > 0) begin
        valid_in[k] = 1'b1;
        state_in[k] = rand128();
        inv_in[k]   = ~inv;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 128'(lat), 128'(4 >> k));
    if (sb.size() == 0) begin
      exp = '0;
      chk("scoreboard_empty", 128'd1, 128'd0);
    end else begin
      exp = sb.pop_front();
    end
    chk("result", state_out[k], exp);
    hold = state_out[k];
    res  = state_out[k];
    for (int n = 0; n < bp; n++) begin
      valid_in[k] = n[0];
      state_in[k] = rand128();
      @(negedge clk);
      chk("bp_valid", 128'(valid_out[k]), 128'd1);
      chk("bp_stable", state_out[k], hold);
    end
    ready_in[k] = 1'b1;
    if (bp > 0) begin
      valid_in[k] = 1'b1;
      state_in[k] = rand128();
    end
    @(negedge clk);
    ready_in[k] = 1'b0;
    valid_in[k] = 1'b0;
    chk("valid_drop", 128'(valid_out[k]), 128'd0);
    chk("out_zero", state_out[k], 128'd0);
    chk("busy_drop", 128'(busy_out[k]), 128'd0);
    $display("txn k=%0d inv=%0d in=%h out=%h", k, inv, st, res);
  endtask

  // valid_i held high with ready_i high: accepts every N+2 cycles.
  task automatic b2b(input int k, input int cnt);
    int cyc, last, acc;
    logic chg;
    logic [127:0] exp;
    cyc = 0; last = -1; acc = 0; chg = 1'b0;
    @(negedge clk);
    valid_in[k] = 1'b1;
    ready_in[k] = 1'b1;
    state_in[k] = rand128();
    inv_in[k]   = 1'($urandom_range(0, 1));
    while ((acc < cnt || sb.size() > 0) && cyc < 400) begin
      if (cyc > 0) @(negedge clk);
      if (chg) begin
        chg = 1'b0;
        if (acc >= cnt) begin
          valid_in[k] = 1'b0;
        end else begin
          state_in[k] = rand128();
          inv_in[k]   = 1'($urandom_range(0, 1));
        end
      end
      if (valid_out[k] && ready_in[k]) begin
        if (sb.size() == 0) begin
          chk("b2b_unexpected_out", 128'd1, 128'd0);
        end else begin
          exp = sb.pop_front();
          chk("b2b_result", state_out[k], exp);
          $display("txn b2b k=%0d out=%h", k, state_out[k]);
        end
      end
      if (ready_out[k] && valid_in[k]) begin
        sb.push_back(model(state_in[k], inv_in[k]));
        if (last >= 0) chk("b2b_spacing", 128'(cyc - last), 128'((4 >> k) + 2));
        last = cyc;
        acc++;
        chg = 1'b1;
      end
      cyc++;
    end
    chk("b2b_accepts", 128'(acc), 128'(cnt));
    chk("b2b_drained", 128'(sb.size()), 128'd0);
    @(negedge clk);
    valid_in[k] = 1'b0;
    ready_in[k] = 1'b0;
    sb.delete();
  endtask

  logic [127:0] res, fwd, back, orig;
  logic [127:0] v_fwd_in, v_fwd_out, v_mix_in, v_mix_out;

  initial begin
    rst      = '1;
    valid_in = '0;
    ready_in = '0;
    inv_in   = '0;
    state_in = '0;
    v_fwd_in  = {4{32'h4553_13db}};
    v_fwd_out = {4{32'hbca1_4d8e}};
    v_mix_in  = {32'h5c22_0af2, 32'h0101_0101, 32'hc6c6_c6c6, 32'h4553_13db};
    v_mix_out = {32'h9d58_dc9f, 32'h0101_0101, 32'hc6c6_c6c6, 32'hbca1_4d8e};

    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_ready", 128'(ready_out[k]), 128'd0);
      chk("rst_valid", 128'(valid_out[k]), 128'd0);
      chk("rst_busy", 128'(busy_out[k]), 128'd0);
      chk("rst_state", state_out[k], 128'd0);
    end
    repeat (3) @(negedge clk);
    rst = '0;
    #1;
    for (int k = 0; k < NDUT; k++) chk("ready_before_edge", 128'(ready_out[k]), 128'd0);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk("ready_after_edge", 128'(ready_out[k]), 128'd1);

    // Directed vectors on every instance.
    for (int k = 0; k < NDUT; k++) begin
      run_one(k, v_fwd_in, 1'b0, 0, res);
      chk("vec_fwd", res, v_fwd_out);
      run_one(k, v_fwd_out, 1'b1, 0, res);
      chk("vec_inv", res, v_fwd_in);
      run_one(k, v_mix_in, 1'b0, 0, res);
      chk("vec_mixed", res, v_mix_out);
    end

    // Backpressure with stray valid pulses in BUSY and DONE.
    for (int k = 0; k < NDUT; k++) begin
      orig = rand128();
      run_one(k, orig, k[0], 10, res);
    end

    // Reset two BUSY edges into a 1-column-per-cycle operation.
    @(negedge clk);
    valid_in[0] = 1'b1;
    state_in[0] = rand128();
    inv_in[0]   = 1'b0;
    @(negedge clk);
    valid_in[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst[0] = 1'b1;
    #1;
    chk("midrst_valid", 128'(valid_out[0]), 128'd0);
    chk("midrst_state", state_out[0], 128'd0);
    chk("midrst_busy", 128'(busy_out[0]), 128'd0);
    chk("midrst_ready", 128'(ready_out[0]), 128'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("midrst_no_valid", 128'(valid_out[0]), 128'd0);
    end
    run_one(0, v_mix_in, 1'b0, 0, res);
    chk("midrst_recover", res, v_mix_out);

    // Back-to-back streaming.
    for (int k = 0; k < NDUT; k++) b2b(k, 8);

    // Forward/inverse round trip on random states.
    for (int i = 0; i < 1000; i++) begin
      orig = rand128();
      run_one(i % NDUT, orig, 1'b0, 0, fwd);
      run_one(i % NDUT, fwd, 1'b1, 0, back);
      chk("roundtrip", back, orig);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
